// File: rtl/r2sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage.
// The phase input selects one of three operations: fill the delay line, run the butterfly, or apply the twiddle and drain.
module r2sdf_butterfly #(
  parameter int DATA_W = 24,
  parameter int FRAC_W = 8,
  parameter int DELAY  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic [1:0]               state,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {ST_FILL, ST_BFLY, ST_TWID, ST_RSVD} phase_e;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] i;
  } cplx_t;

  phase_e ph;
  cplx_t  dl [DELAY];
  cplx_t  x, head, sum, dif, prod, push_val;
  logic   push;

  logic signed [DATA_W-1:0] hr, hi;
  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]       acc_r, acc_i;

  assign ph = phase_e'(state);

  always_comb begin
    x.r  = in_valid ? din_r : '0;
    x.i  = in_valid ? din_i : '0;
    head = dl[0];
    // Add/sub stay at DATA_W and wrap; scaling is handled upstream
    sum.r = head.r + x.r;
    sum.i = head.i + x.i;
    dif.r = head.r - x.r;
    dif.i = head.i - x.i;
    hr    = $signed(head.r);
    hi    = $signed(head.i);
    p_rr  = PW'(hr) * PW'(w_r);
    p_ii  = PW'(hi) * PW'(w_i);
    p_ri  = PW'(hr) * PW'(w_i);
    p_ir  = PW'(hi) * PW'(w_r);
    acc_r = (PW+1)'(p_rr) - (PW+1)'(p_ii);
    acc_i = (PW+1)'(p_ri) + (PW+1)'(p_ir);
    // Arithmetic shift gives floor rounding; the cast wraps to DATA_W
    prod.r = DATA_W'(acc_r >>> FRAC_W);
    prod.i = DATA_W'(acc_i >>> FRAC_W);
  end

  always_comb begin
    push     = 1'b0;
    push_val = x;
    case (ph)
      ST_FILL: push = in_valid;
      ST_BFLY: begin push = 1'b1; push_val = dif; end
      ST_TWID: push = 1'b1;
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DELAY; k++) dl[k] <= '0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      if (push) begin
        for (int k = 0; k < DELAY - 1; k++) dl[k] <= dl[k+1];
        dl[DELAY-1] <= push_val;
      end
      out_valid <= (ph == ST_BFLY) || (ph == ST_TWID);
      if (ph == ST_BFLY) begin
        dout_r <= $signed(sum.r);
        dout_i <= $signed(sum.i);
      end else if (ph == ST_TWID) begin
        dout_r <= $signed(prod.r);
        dout_i <= $signed(prod.i);
      end
    end
  end

endmodule

// File: tb/tb_r2sdf_butterfly.sv
// Scoreboard bench for r2sdf_butterfly at DELAY=2.
// Each cycle pushes a hand-derived expectation; the scenario task pops and checks it after the clock edge.
module tb_r2sdf_butterfly;

  localparam int DW = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [DW-1:0] din_r, din_i, w_r, w_i;
  logic [1:0]           state;
  logic                 out_valid;
  logic signed [DW-1:0] dout_r, dout_i;

  typedef struct {
    logic                 v;
    logic signed [DW-1:0] r;
    logic signed [DW-1:0] i;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic signed [DW-1:0] hold_r = '0, hold_i = '0;

  r2sdf_butterfly #(.DATA_W(DW), .FRAC_W(8), .DELAY(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .state(state), .w_r(w_r), .w_i(w_i),
    .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i)
  );

  always #5 clk = ~clk;

  // Drive one cycle, queue its expected response (held dout when ev=0), then step past the edge.
  task automatic apply(input bit v, input int dr, input int di, input int st,
                       input int wr, input int wi, input bit ev, input int er, input int ei);
    exp_t e;
    in_valid = v; din_r = DW'(dr); din_i = DW'(di); state = 2'(st); w_r = DW'(wr); w_i = DW'(wi);
    if (ev) begin hold_r = DW'(er); hold_i = DW'(ei); end
    e.v = ev; e.r = hold_r; e.i = hold_i;
    sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; din_r = 24'sd777; din_i = -24'sd5; state = 2'd1; w_r = 24'sd256; w_i = 24'sd3;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, dout_r, dout_i} !== {1'b0, 24'sd0, 24'sd0}) begin
      n_err++;
      $display("FAIL reset_async: got v=%0b (%0d,%0d) want v=0 (0,0)", out_valid, dout_r, dout_i);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hold_r = '0; hold_i = '0;
    n_cmp++;
    if ({out_valid, dout_r, dout_i} !== {1'b0, 24'sd0, 24'sd0}) begin
      n_err++;
      $display("FAIL reset_held: got v=%0b (%0d,%0d) want v=0 (0,0)", out_valid, dout_r, dout_i);
    end
  endtask

  task automatic test_basic(input string tag);
    int dr [6] = '{256, 512, 768, 1024, 0, 0};
    bit vv [6] = '{1, 1, 1, 1, 0, 0};
    int st [6] = '{0, 0, 1, 1, 2, 2};
    int wr [6] = '{0, 0, 0, 0, 0, 0};
    int wi [6] = '{0, 0, 0, 0, 0, -256};
    bit ev [6] = '{0, 0, 1, 1, 1, 1};
    int er [6] = '{0, 0, 1024, 1536, -512, 0};
    int ei [6] = '{0, 0, 0, 0, 0, 512};
    exp_t e;
    wr[4] = 256;
    for (int k = 0; k < 6; k++) begin
      apply(vv[k], dr[k], 0, st[k], wr[k], wi[k], ev[k], er[k], ei[k]);
      e = sbq.pop_front();
      n_cmp++;
      if ({out_valid, dout_r, dout_i} !== {e.v, e.r, e.i}) begin
        n_err++;
        $display("FAIL %s[%0d]: got v=%0b (%0d,%0d) want v=%0b (%0d,%0d)",
                 tag, k, out_valid, dout_r, dout_i, e.v, e.r, e.i);
      end
    end
  endtask

  task automatic test_wrap();
    int dr [6] = '{32'h7FFFFF, 0, 1, 0, 0, 0};
    int st [6] = '{0, 0, 1, 1, 2, 2};
    bit ev [6] = '{0, 0, 1, 1, 1, 1};
    int er [6] = '{0, 0, -8388608, 0, 32'h7FFFFE, 0};
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, dr[k], 0, st[k], 256, 0, ev[k], er[k], 0);
      e = sbq.pop_front();
      n_cmp++;
      if ({out_valid, dout_r, dout_i} !== {e.v, e.r, e.i}) begin
        n_err++;
        $display("FAIL wrap[%0d]: got v=%0b (%0d,%0d) want v=%0b (%0d,%0d)",
                 k, out_valid, dout_r, dout_i, e.v, e.r, e.i);
      end
    end
  endtask

  task automatic test_floor();
    int dr [6] = '{0, 0, 3, -3, 0, 0};
    int st [6] = '{0, 0, 1, 1, 2, 2};
    bit ev [6] = '{0, 0, 1, 1, 1, 1};
    int er [6] = '{0, 0, 3, -3, -2, 1};
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, dr[k], 0, st[k], 128, 0, ev[k], er[k], 0);
      e = sbq.pop_front();
      n_cmp++;
      if ({out_valid, dout_r, dout_i} !== {e.v, e.r, e.i}) begin
        n_err++;
        $display("FAIL floor[%0d]: got v=%0b (%0d,%0d) want v=%0b (%0d,%0d)",
                 k, out_valid, dout_r, dout_i, e.v, e.r, e.i);
      end
    end
  endtask

  // Gated fill with a reserved-phase cycle, complex twiddles, then a second block fed by zero-gated state-2 pushes.
  task automatic test_fill_gating();
    bit vv [12] = '{1, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    int dr [12] = '{100, 999, 555, 200, 10, 20, 4321, -77, 50, 60, 0, 0};
    int di [12] = '{5, 777, 888, 9, 1, 2, 1234, 66, 0, 0, 0, 0};
    int st [12] = '{0, 0, 3, 0, 1, 1, 2, 2, 1, 1, 2, 2};
    int wr [12] = '{0, 0, 0, 0, 0, 0, 256, 0, 0, 0, 256, 256};
    int wi [12] = '{0, 0, 0, 0, 0, 0, 0, 256, 0, 0, 0, 0};
    bit ev [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int er [12] = '{0, 0, 0, 0, 110, 220, 90, -7, 50, 60, -50, -60};
    int ei [12] = '{0, 0, 0, 0, 6, 11, 4, 180, 0, 0, 0, 0};
    exp_t e;
    for (int k = 0; k < 12; k++) begin
      apply(vv[k], dr[k], di[k], st[k], wr[k], wi[k], ev[k], er[k], ei[k]);
      e = sbq.pop_front();
      n_cmp++;
      if ({out_valid, dout_r, dout_i} !== {e.v, e.r, e.i}) begin
        n_err++;
        $display("FAIL fill_gating[%0d]: got v=%0b (%0d,%0d) want v=%0b (%0d,%0d)",
                 k, out_valid, dout_r, dout_i, e.v, e.r, e.i);
      end
    end
  endtask

  task automatic test_mid_reset();
    int dr [3] = '{256, 512, 768};
    int st [3] = '{0, 0, 1};
    bit ev [3] = '{0, 0, 1};
    int er [3] = '{0, 0, 1024};
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, dr[k], 0, st[k], 0, 0, ev[k], er[k], 0);
      e = sbq.pop_front();
      n_cmp++;
      if ({out_valid, dout_r, dout_i} !== {e.v, e.r, e.i}) begin
        n_err++;
        $display("FAIL mid_reset_pre[%0d]: got v=%0b (%0d,%0d) want v=%0b (%0d,%0d)",
                 k, out_valid, dout_r, dout_i, e.v, e.r, e.i);
      end
    end
    in_valid = 1'b1; din_r = 24'sd1024; din_i = '0; state = 2'd1;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, dout_r, dout_i} !== {1'b0, 24'sd0, 24'sd0}) begin
      n_err++;
      $display("FAIL mid_reset_async: got v=%0b (%0d,%0d) want v=0 (0,0)", out_valid, dout_r, dout_i);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    hold_r = '0; hold_i = '0;
    test_basic("mid_reset_replay");
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; din_r = '0; din_i = '0; state = '0; w_r = '0; w_i = '0;
    test_reset();
    test_basic("basic");
    test_wrap();
    test_floor();
    test_fill_gating();
    test_mid_reset();
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/r2sdf_butterfly.md
Name: r2sdf_butterfly

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the 64-point FFT datapath.
- Consumes the stage phase (state) and twiddle pair (w_r, w_i) from the twiddle/phase generator of the same stage.
- Performs delay-line buffering, butterfly add/subtract and complex twiddle multiply; emits one complex sample per cycle to the next stage.
- Default instance is the DELAY=2 stage, which uses twiddles W4^0 and W4^1.

Parameters:
- DATA_W, 24, two's-complement width of each real and imag component.
- FRAC_W, 8, fractional bits; 1.0 = 256 at defaults.
- DELAY, 2, delay-line depth in complex samples (half the butterfly span); integer >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  din_r/din_i carry a valid sample this cycle.
- din_r  in  DATA_W  input sample, real part, signed.
- din_i  in  DATA_W  input sample, imag part, signed.
- state  in  2  phase from the generator: 0 fill, 1 butterfly, 2 twiddle-out; 3 reserved.
- w_r  in  DATA_W  twiddle real part, signed QX.FRAC_W; used only in state 2.
- w_i  in  DATA_W  twiddle imag part, signed QX.FRAC_W; used only in state 2.
- out_valid  out  1  dout_r/dout_i carry a valid sample.
- dout_r  out  DATA_W  output sample, real part.
- dout_i  out  DATA_W  output sample, imag part.

Behaviour:
- Single clock domain, clk. rst is asynchronous, active-high: it clears all DELAY delay-line entries and forces out_valid=0, dout_r=0, dout_i=0 immediately.
- Reset mid-operation discards all buffered data. After release the block waits for a fresh state-0 fill.
- Effective input x = din when in_valid=1, else 0 (complex zero).
- Delay line: shift register of DELAY complex entries. head = oldest entry. A push writes the tail and drops the head.
- state 0 (fill):
  - if in_valid=1, push x; otherwise the delay line holds.
  - next cycle out_valid=0; dout holds its last value.
- state 1 (butterfly), with a = head and b = x:
  - register dout <= a+b, per component.
  - push a-b (per component) into the delay line.
  - next cycle out_valid=1.
- state 2 (twiddle-out), with d = head (a stored difference):
  - push x.
  - register dout <= d*w, where real = (d_r*w_r - d_i*w_i) >>> FRAC_W and imag = (d_r*w_i + d_i*w_r) >>> FRAC_W.
  - next cycle out_valid=1.
- state 3: no push, out_valid=0 next cycle, dout holds its last value.
- Latency: exactly 1 cycle from the state-1/2 input cycle to the registered output. No stall, no backpressure.
- Arithmetic:
  - a+b and a-b are computed at DATA_W with two's-complement wrap; no growth, no saturation (scaling is owned upstream).
  - Products are full 2*DATA_W signed, summed at 2*DATA_W+1, arithmetically shifted right by FRAC_W (floor), then truncated to DATA_W with wrap.
- Flush: state 2 drains the delay line even when in_valid=0, so a block's last DELAY outputs appear with zero input.
- The generator sequences state as 0 for DELAY cycles, then repeating DELAY×1 and DELAY×2. The block does not check the sequence; illegal orders produce defined but meaningless data.

Test Plan:
- Reset: assert rst with arbitrary inputs -> out_valid=0, dout_r=0, dout_i=0 in the same cycle, with no clk edge required.
- Basic block, DELAY=2:
  - stimulus: din_r = 256, 512, 768, 1024, then 0, 0; din_i=0; in_valid=1, 1, 1, 1, 0, 0; state = 0, 0, 1, 1, 2, 2; w in state 2 = (256, 0) then (0, -256).
  - required response, one cycle later: out_valid 0, 0, 1, 1, 1, 1; dout = (1024, 0), (1536, 0), (-512, 0), (0, 512).
- Wrap: din a=(0x7FFFFF, 0) then b=(1, 0) in state 1 -> dout_r=0x800000. Stored difference 0x7FFFFE appears with w=(256, 0) in the following state 2.
- Floor rounding: difference (-3, 0) with w=(128, 0) -> dout=(-2, 0); difference (3, 0) -> (1, 0).
- Fill gating: state 0 with in_valid toggling 1, 0, 1 -> only 2 pushes; the following state-1 sums use those two samples, not zero.
- Mid-block reset: assert rst during the 2nd state-1 cycle, release, then replay the basic block -> outputs identical to the basic block, with no residue from the aborted data.
